// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch front-end: opcode field and FIFO entry layout.
package ifetch_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b000001;
  localparam logic [5:0] OPC_SW    = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000011;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  // Entry fields are sized for the widest supported build; narrower builds zero-extend.
  localparam int ENTRY_PC_W    = 32;
  localparam int ENTRY_INSTR_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries with push/pop/flush; head is always a register.
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  ifetch_entry_t din,
  output ifetch_entry_t head,
  output logic [1:0]    count
);

  ifetch_entry_t e0, e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new entry lands behind the survivor.
          if (count == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        2'b01: begin
          if (count != 2'd0) begin
            e0    <= e1;
            count <= count - 2'd1;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            e0    <= din;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            e1    <= din;
            count <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: fetch PC, redirect handling and 2-entry output queue.
// Optional HALT-opcode stop is enabled with `define IFETCH_HALT_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter int          INSTR_W  = 32,
  parameter int          DEPTH    = 256,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ins_valid,
  output logic [INSTR_W-1:0] ins_data,
  output logic [PC_W-1:0]    ins_pc,
  input  logic               ins_ready,
  output logic               halted
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] fetch_pc;
  logic [1:0]    count;
  logic          pop, fetch, push;
  ifetch_entry_t din, head;

  assign pop   = ins_valid & ins_ready & ~redirect_valid;
  assign fetch = ~halted & ((count != 2'd2) | (ins_valid & ins_ready));
  assign push  = fetch & ~redirect_valid;

  assign din.pc    = ENTRY_PC_W'(fetch_pc);
  assign din.instr = ENTRY_INSTR_W'(imem_instr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_pc <= AW'(RESET_PC);
    else if (redirect_valid)
      fetch_pc <= redirect_pc[AW-1:0];
    else if (push)
      fetch_pc <= fetch_pc + AW'(1);
  end

`ifdef IFETCH_HALT_EN
  logic halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      halted_q <= 1'b0;
    else if (redirect_valid)
      halted_q <= 1'b0;
    else if (push && (imem_instr[OPC_MSB:OPC_LSB] == OPC_HALT))
      halted_q <= 1'b1;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  ifetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign imem_pc   = PC_W'(fetch_pc);
  assign ins_valid = (count != 2'd0);
  assign ins_data  = INSTR_W'(head.instr);
  assign ins_pc    = PC_W'(head.pc[AW-1:0]);

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[PC_W-1:AW], head.pc[ENTRY_PC_W-1:AW]};

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; adapts HALT expectations to IFETCH_HALT_EN.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic        halted;

  logic [31:0] mem [0:255];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc[7:0]];

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 + i;
    mem[0] = 32'h0401_0000;
    mem[1] = 32'h0021_1000;

    rst_n = 1'b0; ins_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    check("rst_valid",  ins_valid, 0);
    check("rst_imempc", imem_pc, 0);
    check("rst_data",   ins_data, 0);
    check("rst_pc",     ins_pc, 0);
    check("rst_halted", halted, 0);

    // Streaming from reset
    rst_n = 1'b1;
    step();
    check("str_valid0", ins_valid, 1);
    check("str_pc0",    ins_pc, 0);
    check("str_data0",  ins_data, 32'h0401_0000);
    check("str_imem0",  imem_pc, 1);
    step();
    check("str_pc1",    ins_pc, 1);
    check("str_data1",  ins_data, 32'h0021_1000);
    step();
    check("str_pc2",    ins_pc, 2);
    check("str_data2",  ins_data, 32'h2000_0002);
    step();
    check("str_pc3",    ins_pc, 3);

    // Backpressure from reset
    rst_n = 1'b0; ins_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", ins_valid, 1);
      check("bp_pc",    ins_pc, 0);
    end
    check("bp_imem", imem_pc, 2);
    ins_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("bp_rel_pc", ins_pc, i);
      check("bp_rel_v",  ins_valid, 1);
    end
    check("bp_q_imem", imem_pc, 7);

    // Redirect to 0 while queue holds 5,6
    do_redirect(32'h0);
    check("rd0_valid", ins_valid, 0);
    check("rd0_imem",  imem_pc, 0);
    step();
    check("rd0_v2",    ins_valid, 1);
    check("rd0_pc",    ins_pc, 0);
    check("rd0_data",  ins_data, 32'h0401_0000);
    step();
    check("rd0_pc1",   ins_pc, 1);

    // Redirect with upper bits set: only low 8 bits matter
    do_redirect(32'h105);
    check("rd105_valid", ins_valid, 0);
    check("rd105_imem",  imem_pc, 5);
    step();
    check("rd105_pc",    ins_pc, 5);
    check("rd105_data",  ins_data, 32'h2000_0005);

    // Wrap at DEPTH-1
    do_redirect(32'd255);
    check("wrap_imem", imem_pc, 255);
    step();
    check("wrap_pc255", ins_pc, 255);
    check("wrap_imem0", imem_pc, 0);
    step();
    check("wrap_pc0",   ins_pc, 0);
    step();
    check("wrap_pc1",   ins_pc, 1);

    // HALT opcode at word 3
    mem[3] = 32'hFC00_0000;
    do_redirect(32'h0);
    step(); step(); step();
    check("h_pc2", ins_pc, 2);
    check("h_halted_pre", halted, 0);
    step();
    check("h_pc3",   ins_pc, 3);
    check("h_data3", ins_data, 32'hFC00_0000);
`ifdef IFETCH_HALT_EN
    check("h_halted", halted, 1);
    step();
    check("h_valid_drop", ins_valid, 0);
    check("h_imem4", imem_pc, 4);
    step();
    check("h_imem_hold", imem_pc, 4);
    check("h_still", halted, 1);
    do_redirect(32'h0);
    check("h_clear", halted, 0);
    check("h_clear_v", ins_valid, 0);
    step();
    check("h_resume_v",  ins_valid, 1);
    check("h_resume_pc", ins_pc, 0);
`else
    check("h_halted_off", halted, 0);
    step();
    check("h_next_v",  ins_valid, 1);
    check("h_next_pc", ins_pc, 4);
    do_redirect(32'h0);
    step();
    check("h_resume_pc", ins_pc, 0);
`endif

    // Asynchronous reset with a full queue
    ins_ready = 1'b0;
    step();
    check("mr_full_v", ins_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", ins_valid, 0);
    check("mr_imem",  imem_pc, 0);
    check("mr_data",  ins_data, 0);
    step();
    rst_n = 1'b1; ins_ready = 1'b1;
    step();
    check("mr_rest_v",  ins_valid, 1);
    check("mr_rest_pc", ins_pc, 0);
    step();
    check("mr_rest_pc1", ins_pc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
